// File: rtl/stack_unit.sv
// ---------------------------------------------------------------------------
// stack_unit
//
// Hardware operand stack driven by the control unit's stack commands.
// The top element lives in a register so it is always visible on
// STACK_TOP_OUT. Deeper elements live in a synchronous single-port RAM.
// A two-state FSM (IDLE / REFILL) reloads the top register from the RAM
// after a pop that leaves at least one element behind.
//
// Optional feature (macro STACK_PEEK_EN):
//   When defined, a second RAM read port returns any stack element on
//   PEEK_DATA one cycle after PEEK_ADDR is presented. When undefined,
//   PEEK_ADDR is ignored and PEEK_DATA is tied to 0.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous active-low reset
//   CTRL_STACK_EN        command strobe (ignored while STACK_BUSY=1)
//   CTRL_STACK_FUNCTION  1 = push, 0 = pop
//   STACK_IN             push data
//   CLEAR_ERROR          clears the sticky STACK_ERROR flag
//   STACK_TOP_OUT        current top element, 0 when empty
//   TOS_OUT              element count
//   STACK_BUSY           refill in progress
//   STACK_EMPTY          TOS_OUT == 0
//   STACK_FULL           TOS_OUT == STACK_DEPTH
//   STACK_ERROR          sticky overflow/underflow flag
//   PEEK_ADDR            debug read address
//   PEEK_DATA            debug read data
// ---------------------------------------------------------------------------
module stack_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CTRL_STACK_EN,
    input  logic                  CTRL_STACK_FUNCTION,
    input  logic [DATA_WIDTH-1:0] STACK_IN,
    input  logic                  CLEAR_ERROR,
    output logic [DATA_WIDTH-1:0] STACK_TOP_OUT,
    output logic [ADDR_WIDTH-1:0] TOS_OUT,
    output logic                  STACK_BUSY,
    output logic                  STACK_EMPTY,
    output logic                  STACK_FULL,
    output logic                  STACK_ERROR,
    input  logic [ADDR_WIDTH-1:0] PEEK_ADDR,
    output logic [DATA_WIDTH-1:0] PEEK_DATA
);

    // The RAM only holds the elements below the top register.
    localparam int RAM_WORDS = STACK_DEPTH - 1;
    localparam int RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_CNT = ADDR_WIDTH'(STACK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_CNT   = ADDR_WIDTH'(1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state, next_state;

    logic [ADDR_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] top_reg;
    logic                  error_flag;

    logic [DATA_WIDTH-1:0] mem [0:RAM_WORDS-1];
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic cmd_valid;
    logic do_push;
    logic do_pop;
    logic pop_refill;
    logic pop_last;
    logic overflow;
    logic underflow;

    logic [RAM_AW-1:0] ram_waddr;
    logic [RAM_AW-1:0] ram_raddr;

    // Commands are only accepted in IDLE; anything arriving during a
    // refill is silently dropped without raising an error.
    always_comb begin
        cmd_valid  = CTRL_STACK_EN && (state == IDLE);
        do_push    = cmd_valid &&  CTRL_STACK_FUNCTION && (count != DEPTH_CNT);
        overflow   = cmd_valid &&  CTRL_STACK_FUNCTION && (count == DEPTH_CNT);
        do_pop     = cmd_valid && !CTRL_STACK_FUNCTION && (count != '0);
        underflow  = cmd_valid && !CTRL_STACK_FUNCTION && (count == '0);
        pop_refill = do_pop && (count > ONE_CNT);
        pop_last   = do_pop && (count == ONE_CNT);
        ram_waddr  = RAM_AW'(count - ONE_CNT);
        ram_raddr  = RAM_AW'(count - ADDR_WIDTH'(2));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic: a pop with elements left below the top
    // spends one extra cycle waiting for the RAM read data.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop_refill) next_state = REFILL;
            REFILL:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        STACK_BUSY = (state == REFILL);
    end

    // Count, top register and sticky error flag. A new fault on the same
    // cycle as CLEAR_ERROR keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            top_reg    <= '0;
            error_flag <= 1'b0;
        end else begin
            if (do_push) begin
                top_reg <= STACK_IN;
                count   <= count + ONE_CNT;
            end else if (do_pop) begin
                count <= count - ONE_CNT;
                if (pop_last) top_reg <= '0;
            end else if (state == REFILL) begin
                top_reg <= ram_rdata;
            end

            if (overflow || underflow) begin
                error_flag <= 1'b1;
            end else if (CLEAR_ERROR) begin
                error_flag <= 1'b0;
            end
        end
    end

    // Main RAM port: a push spills the old top to RAM[count-1]; a pop
    // that needs a refill reads RAM[count-2] for the REFILL cycle.
    always_ff @(posedge clk) begin
        if (do_push && (count != '0)) begin
            mem[ram_waddr] <= top_reg;
        end
        if (pop_refill) begin
            ram_rdata <= mem[ram_raddr];
        end
    end

`ifdef STACK_PEEK_EN
    // Debug read port: the top element is not in RAM, so an address that
    // hits count-1 is served from the top register instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PEEK_DATA <= '0;
        end else if (PEEK_ADDR >= count) begin
            PEEK_DATA <= '0;
        end else if (PEEK_ADDR == (count - ONE_CNT)) begin
            PEEK_DATA <= top_reg;
        end else begin
            PEEK_DATA <= mem[RAM_AW'(PEEK_ADDR)];
        end
    end
`else
    logic unused_peek;
    assign unused_peek = ^PEEK_ADDR;
    assign PEEK_DATA   = '0;
`endif

    assign STACK_TOP_OUT = top_reg;
    assign TOS_OUT       = count;
    assign STACK_EMPTY   = (count == '0);
    assign STACK_FULL    = (count == DEPTH_CNT);
    assign STACK_ERROR   = error_flag;

endmodule

// File: tb/tb_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_unit
//
// Directed self-checking bench for stack_unit, built with STACK_DEPTH=4 so
// the full/overflow boundary is reachable. Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_stack_unit;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int SD = 4;

    logic          clk;
    logic          reset;
    logic          CTRL_STACK_EN;
    logic          CTRL_STACK_FUNCTION;
    logic [DW-1:0] STACK_IN;
    logic          CLEAR_ERROR;
    logic [DW-1:0] STACK_TOP_OUT;
    logic [AW-1:0] TOS_OUT;
    logic          STACK_BUSY;
    logic          STACK_EMPTY;
    logic          STACK_FULL;
    logic          STACK_ERROR;
    logic [AW-1:0] PEEK_ADDR;
    logic [DW-1:0] PEEK_DATA;

    int assertCount = 0;
    int failCount   = 0;

    stack_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(SD)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .CTRL_STACK_EN      (CTRL_STACK_EN),
        .CTRL_STACK_FUNCTION(CTRL_STACK_FUNCTION),
        .STACK_IN           (STACK_IN),
        .CLEAR_ERROR        (CLEAR_ERROR),
        .STACK_TOP_OUT      (STACK_TOP_OUT),
        .TOS_OUT            (TOS_OUT),
        .STACK_BUSY         (STACK_BUSY),
        .STACK_EMPTY        (STACK_EMPTY),
        .STACK_FULL         (STACK_FULL),
        .STACK_ERROR        (STACK_ERROR),
        .PEEK_ADDR          (PEEK_ADDR),
        .PEEK_DATA          (PEEK_DATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs starting at a falling edge; returns at the
    // next falling edge with the strobes dropped again.
    task automatic applyStimulus(input logic en, input logic func,
                                 input logic [DW-1:0] data, input logic clr);
        CTRL_STACK_EN       = en;
        CTRL_STACK_FUNCTION = func;
        STACK_IN            = data;
        CLEAR_ERROR         = clr;
        @(negedge clk);
        CTRL_STACK_EN = 1'b0;
        CLEAR_ERROR   = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] data);
        applyStimulus(1'b1, 1'b1, data, 1'b0);
    endtask

    task automatic pop();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] expPeek;
        reset               = 1'b0;
        CTRL_STACK_EN       = 1'b0;
        CTRL_STACK_FUNCTION = 1'b0;
        STACK_IN            = '0;
        CLEAR_ERROR         = 1'b0;
        PEEK_ADDR           = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_tos",   32'(TOS_OUT), 0);
        checkOutput("rst_top",   32'(STACK_TOP_OUT), 0);
        checkOutput("rst_empty", 32'(STACK_EMPTY), 1);
        checkOutput("rst_full",  32'(STACK_FULL), 0);
        checkOutput("rst_busy",  32'(STACK_BUSY), 0);
        checkOutput("rst_err",   32'(STACK_ERROR), 0);
        checkOutput("rst_peek",  32'(PEEK_DATA), 0);
        reset = 1'b1;
        @(negedge clk);

        // Three back-to-back pushes
        push(8'h11);
        checkOutput("push1_busy", 32'(STACK_BUSY), 0);
        checkOutput("push1_top",  32'(STACK_TOP_OUT), 32'h11);
        push(8'h22);
        checkOutput("push2_busy", 32'(STACK_BUSY), 0);
        push(8'h33);
        checkOutput("push3_busy", 32'(STACK_BUSY), 0);
        checkOutput("push3_tos",  32'(TOS_OUT), 3);
        checkOutput("push3_top",  32'(STACK_TOP_OUT), 32'h33);
        checkOutput("push3_empty", 32'(STACK_EMPTY), 0);

        // Debug peek with three elements
        PEEK_ADDR = 12'd0;
        @(negedge clk);
`ifdef STACK_PEEK_EN
        expPeek = 8'h11;
`else
        expPeek = 8'h00;
`endif
        checkOutput("peek0", 32'(PEEK_DATA), 32'(expPeek));
        PEEK_ADDR = 12'd2;
        @(negedge clk);
`ifdef STACK_PEEK_EN
        expPeek = 8'h33;
`else
        expPeek = 8'h00;
`endif
        checkOutput("peek2", 32'(PEEK_DATA), 32'(expPeek));
        PEEK_ADDR = 12'd5;
        @(negedge clk);
        checkOutput("peek5", 32'(PEEK_DATA), 0);
        PEEK_ADDR = 12'd0;

        // Pop from three: refill cycle, with a push ignored while busy
        pop();
        checkOutput("pop3_busy", 32'(STACK_BUSY), 1);
        checkOutput("pop3_tos",  32'(TOS_OUT), 2);
        push(8'h77);
        checkOutput("pop3_busy_end", 32'(STACK_BUSY), 0);
        checkOutput("pop3_top",      32'(STACK_TOP_OUT), 32'h22);
        checkOutput("ign_push_tos",  32'(TOS_OUT), 2);
        checkOutput("ign_push_err",  32'(STACK_ERROR), 0);

        // Pop from two: refill restores 0x11
        pop();
        checkOutput("pop2_busy", 32'(STACK_BUSY), 1);
        idle();
        checkOutput("pop2_top", 32'(STACK_TOP_OUT), 32'h11);
        checkOutput("pop2_tos", 32'(TOS_OUT), 1);

        // Pop at count==1: no refill
        pop();
        checkOutput("pop1_tos",   32'(TOS_OUT), 0);
        checkOutput("pop1_empty", 32'(STACK_EMPTY), 1);
        checkOutput("pop1_top",   32'(STACK_TOP_OUT), 0);
        checkOutput("pop1_busy",  32'(STACK_BUSY), 0);

        // Underflow and sticky error handling
        pop();
        checkOutput("uflow_err", 32'(STACK_ERROR), 1);
        checkOutput("uflow_tos", 32'(TOS_OUT), 0);
        idle();
        checkOutput("err_sticky", 32'(STACK_ERROR), 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("err_clear", 32'(STACK_ERROR), 0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("err_wins", 32'(STACK_ERROR), 1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("err_clear2", 32'(STACK_ERROR), 0);

        // Fill to depth, then overflow
        push(8'hA1);
        push(8'hA2);
        push(8'hA3);
        checkOutput("fill3_full", 32'(STACK_FULL), 0);
        push(8'hA4);
        checkOutput("fill_full", 32'(STACK_FULL), 1);
        checkOutput("fill_tos",  32'(TOS_OUT), 4);
        checkOutput("fill_err",  32'(STACK_ERROR), 0);
        push(8'hAA);
        checkOutput("oflow_err",  32'(STACK_ERROR), 1);
        checkOutput("oflow_full", 32'(STACK_FULL), 1);
        checkOutput("oflow_tos",  32'(TOS_OUT), 4);
        checkOutput("oflow_top",  32'(STACK_TOP_OUT), 32'hA4);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        // Drain in LIFO order
        pop();
        checkOutput("drain4_full", 32'(STACK_FULL), 0);
        idle();
        checkOutput("drain4_top", 32'(STACK_TOP_OUT), 32'hA3);
        checkOutput("drain4_tos", 32'(TOS_OUT), 3);
        pop();
        idle();
        checkOutput("drain3_top", 32'(STACK_TOP_OUT), 32'hA2);
        pop();
        idle();
        checkOutput("drain2_top", 32'(STACK_TOP_OUT), 32'hA1);
        checkOutput("drain2_tos", 32'(TOS_OUT), 1);
        pop();
        checkOutput("drain1_tos", 32'(TOS_OUT), 0);
        checkOutput("drain1_top", 32'(STACK_TOP_OUT), 0);
        checkOutput("drain_err",  32'(STACK_ERROR), 0);

        // Asynchronous reset in the middle of a refill
        push(8'h05);
        push(8'h06);
        pop();
        checkOutput("pre_rst_busy", 32'(STACK_BUSY), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy",  32'(STACK_BUSY), 0);
        checkOutput("midrst_tos",   32'(TOS_OUT), 0);
        checkOutput("midrst_top",   32'(STACK_TOP_OUT), 0);
        checkOutput("midrst_empty", 32'(STACK_EMPTY), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("postrst_busy", 32'(STACK_BUSY), 0);
        checkOutput("postrst_top",  32'(STACK_TOP_OUT), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack that responds to the control unit's stack commands.
- Consumes CTRL_STACK_FUNCTION, STACK_OUT and an enable from the control unit; returns the top-of-stack data and the TOS_IN pointer.
- Top element is held in a register; deeper elements live in a synchronous single-port RAM.
- A small FSM refills the top register after a pop.

Parameters:
- DATA_WIDTH, 8, width of one stack element.
- ADDR_WIDTH, 12, width of the TOS pointer/count.
- STACK_DEPTH, 1024, maximum number of elements. Must be at most 2**ADDR_WIDTH - 1. RAM holds STACK_DEPTH-1 words.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- CTRL_STACK_EN  in  1  command strobe; sampled only when STACK_BUSY=0.
- CTRL_STACK_FUNCTION  in  1  1=push, 0=pop.
- STACK_IN  in  DATA_WIDTH  push data (control unit STACK_OUT).
- CLEAR_ERROR  in  1  clears STACK_ERROR.
- STACK_TOP_OUT  out  DATA_WIDTH  current top element; 0 when empty.
- TOS_OUT  out  ADDR_WIDTH  element count (feeds control unit TOS_IN).
- STACK_BUSY  out  1  refill in progress; commands ignored.
- STACK_EMPTY  out  1  TOS_OUT==0.
- STACK_FULL  out  1  TOS_OUT==STACK_DEPTH.
- STACK_ERROR  out  1  sticky overflow/underflow flag.
- PEEK_ADDR  in  ADDR_WIDTH  debug read address (see Optional Feature).
- PEEK_DATA  out  DATA_WIDTH  debug read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, TOP_REG=0, state=IDLE.
  - STACK_BUSY=0, STACK_ERROR=0, PEEK_DATA=0.
  - STACK_EMPTY=1, STACK_FULL=0.
  - RAM contents undefined. Reset mid-refill aborts the refill.
- Storage model: TOP_REG holds element count-1. RAM[i] holds element i for i in 0..count-2.
- FSM states: IDLE, REFILL.
- Push in IDLE, count<STACK_DEPTH (1-cycle latency):
  - if count>=1, write RAM[count-1]<=TOP_REG;
  - TOP_REG<=STACK_IN; count<=count+1;
  - stay in IDLE.
- Pop in IDLE, count>=2:
  - issue RAM read at count-2; count<=count-1;
  - go to REFILL; STACK_BUSY=1 during REFILL.
- REFILL:
  - TOP_REG<=RAM read data; return to IDLE with BUSY=0.
  - Total pop latency is 2 cycles; STACK_TOP_OUT is valid on the cycle BUSY falls.
- Pop in IDLE, count==1: count<=0, TOP_REG<=0, no refill, 1-cycle latency.
- Overflow (push with count==STACK_DEPTH): state unchanged; STACK_ERROR<=1.
- Underflow (pop with count==0): state unchanged; STACK_ERROR<=1.
- STACK_ERROR is sticky until CLEAR_ERROR=1 or reset.
  - If CLEAR_ERROR coincides with a new overflow/underflow, the error wins (flag stays 1).
- Commands arriving while STACK_BUSY=1 are ignored, with no error and no state change. The control unit must hold off.
- TOS_OUT, STACK_EMPTY and STACK_FULL are registered-state-derived and change the cycle after the command edge.
- Never wraps: count is clamped by the overflow/underflow rules.

Optional Feature:
- Macro STACK_PEEK_EN.
- When defined:
  - PEEK_DATA<=RAM[PEEK_ADDR] with 1-cycle latency, via a second read port.
  - If PEEK_ADDR==count-1, PEEK_DATA returns TOP_REG instead.
  - If PEEK_ADDR>=count, PEEK_DATA=0.
- When undefined: PEEK_ADDR is ignored, PEEK_DATA is tied to 0, and the RAM is single-read-port.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles:
  - TOS_OUT=3, STACK_TOP_OUT=0x33, BUSY never asserted.
- Pop from 3 elements:
  - BUSY=1 for one cycle, then STACK_TOP_OUT=0x22, TOS_OUT=2.
  - Assert a push during BUSY; it must be ignored (TOS_OUT stays 2).
- Pop at count=1:
  - next cycle TOS_OUT=0, STACK_EMPTY=1, STACK_TOP_OUT=0, BUSY=0.
- Pop at count=0:
  - STACK_ERROR=1, TOS_OUT=0.
  - CLEAR_ERROR pulse returns it to 0.
  - CLEAR_ERROR together with another underflow keeps it at 1.
- Fill to STACK_DEPTH (use STACK_DEPTH=4 override), then push 0xAA:
  - STACK_FULL=1, STACK_ERROR=1, STACK_TOP_OUT unchanged.
  - Pop all four, checking LIFO order.
- Assert reset during REFILL:
  - outputs return to reset values immediately.
- With STACK_PEEK_EN, 3 elements pushed:
  - PEEK_ADDR=0 gives 0x11; PEEK_ADDR=2 gives the top value; PEEK_ADDR=5 gives 0.
